pipelined_carry_adder: RTL and testbench

Parametrised, pipelined successor to the team's combinational ripple-carry adder. Adds or subtracts two N-bit operands by splitting the carry chain into STAGES register-separated slices of N/STAGES bits, accepting one operation per cycle through a valid/ready handshake with full backpressure. Sits between operand producers (register file / datapath muxes) and result consumers where a full N-bit ripple chain would not meet timing.

---
 rtl/pipelined_carry_adder.sv | 144 ++++++++++++++
 tb/tb_pipelined_carry_adder.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder
//   Adds or subtracts two N-bit operands. The carry chain is split into
//   STAGES register-separated slices of W = N/STAGES bits. It accepts one
//   operation per cycle and supports full backpressure.
//
//   Handshake: a transfer happens on a rising edge only when valid and ready
//   are both 1. This applies to the input side (in_valid/in_ready) and to the
//   output side (out_valid/out_ready). The producer holds its operands stable
//   until it is accepted. The consumer sees Sum/Cout/Ovf held stable until it
//   takes them.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid / in_ready    operand handshake (A, B, Cin, sub)
//   A, B                   N-bit operands
//   Cin                    carry-in, used only when sub = 0
//   sub                    0: A+B+Cin   1: A-B computed as A+~B+1
//   out_valid / out_ready  result handshake (Sum, Cout, Ovf)
//   Sum                    N-bit result, modulo 2^N
//   Cout                   carry out of bit N-1 (for sub: 1 = no borrow)
//   Ovf                    two's-complement overflow
module pipelined_carry_adder #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         Ovf
);
    localparam int W = N / STAGES;

    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_param
        $error("pipelined_carry_adder: STAGES must be in 1..N and divide N");
    end

    // en[k]: stage k may load this cycle. A stage loads when it is empty or
    // when its successor is loading. The chain is combinational, so a bubble
    // anywhere lets every stage below it move in the same cycle.
    logic [STAGES:0] en;
    assign en[STAGES] = out_ready;
    assign in_ready   = !rst && en[0];

    for (genvar k = 0; k < STAGES; k++) begin : stage
        // RW counts the operand bits that are not yet added on entry to this
        // stage. Slice k sits in the low W bits of the remaining operands.
        localparam int RW = N - k * W;

        logic [RW-1:0]      a_src;
        logic [RW-1:0]      b_src;
        logic               c_src;
        logic               v_src;
        logic [W:0]         slice;
        logic [(k+1)*W-1:0] s_nxt;

        logic               v_r;
        logic               c_r;
        logic [(k+1)*W-1:0] s_r;

        if (k == 0) begin : g_first
            // Subtraction inverts B and forces the carry-in at acceptance.
            assign a_src = A;
            assign b_src = sub ? ~B : B;
            assign c_src = sub ? 1'b1 : Cin;
            assign v_src = in_valid;
        end else begin : g_next
            assign a_src = stage[k-1].g_rem.a_r;
            assign b_src = stage[k-1].g_rem.b_r;
            assign c_src = stage[k-1].c_r;
            assign v_src = stage[k-1].v_r;
        end

        assign slice = {1'b0, a_src[W-1:0]} + {1'b0, b_src[W-1:0]} + {{W{1'b0}}, c_src};

        if (k == 0) begin : g_sum_first
            assign s_nxt = slice[W-1:0];
        end else begin : g_sum_next
            assign s_nxt = {slice[W-1:0], stage[k-1].s_r};
        end

        assign en[k] = !v_r || en[k+1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (en[k]) begin
                v_r <= v_src;
                if (v_src) begin
                    c_r <= slice[W];
                    s_r <= s_nxt;
                end
            end
        end

        if (k < STAGES - 1) begin : g_rem
            // Upper operand slices that later stages still have to add.
            logic [RW-W-1:0] a_r;
            logic [RW-W-1:0] b_r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (en[k] && v_src) begin
                    a_r <= a_src[RW-1:W];
                    b_r <= b_src[RW-1:W];
                end
            end
        end else begin : g_last
            // Carry into bit N-1 is the sum bit XOR both operand bits. The
            // overflow flag is registered here so that Ovf is a plain
            // register output.
            logic c_msb;
            logic ovf_r;

            assign c_msb = a_src[W-1] ^ b_src[W-1] ^ slice[W-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (en[k] && v_src) begin
                    ovf_r <= slice[W] ^ c_msb;
                end
            end
        end
    end

    assign out_valid = stage[STAGES-1].v_r;
    assign Sum       = stage[STAGES-1].s_r;
    assign Cout      = stage[STAGES-1].c_r;
    assign Ovf       = stage[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
module tb_pipelined_carry_adder;
    localparam int N = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sb;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_vec  = 0;
    int n_fail = 0;
    logic corner_go = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    pipelined_carry_adder #(.N(N), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .Cin(cin), .sub(sb),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(sum), .Cout(cout), .Ovf(ovf)
    );

    // ---------------- golden model: {Cout, Ovf, Sum} ----------------
    function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic c, input logic s);
        logic [N-1:0] ye;
        logic [N:0]   full;
        logic         v;
        ye   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, ye} + {{N{1'b0}}, (s ? 1'b1 : c)};
        v    = (x[N-1] == ye[N-1]) && (full[N-1] != x[N-1]);
        return {full[N], v, full[N-1:0]};
    endfunction

    // ---------------- scoreboard for the main instance ----------------
    logic [N+1:0] exp_q[$];
    logic [N+1:0] exp_v;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() > S) begin
                    n_fail++;
                    $display("FAIL main_inflight: got %0d in flight, required at most %0d", exp_q.size(), S);
                end
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL main_unexpected: got result %h, required no result", {cout, ovf, sum});
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({cout, ovf, sum} !== exp_v) begin
                        n_fail++;
                        $display("FAIL main_result: got cout/ovf/sum %h, required %h", {cout, ovf, sum}, exp_v);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sb));
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic drive_op(input logic [N-1:0] x, input logic [N-1:0] y,
                            input logic c, input logic s, output logic ok);
        logic took;
        int   t;
        a = x; b = y; cin = c; sb = s; in_valid = 1'b1;
        took = 1'b0;
        t = 0;
        while (!took && t < 200) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        ok = took;
    endtask

    // lat counts edges from the acceptance edge (inclusive) until out_valid.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sb = 1'b0;
        #2;
        n_vec++;
        if ({out_valid, cout, ovf, sum} !== {3'b000, {N{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid/cout/ovf/sum %b/%b/%b/%h, required 0/0/0/0",
                     out_valid, cout, ovf, sum);
        end
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    // Directed table: carry ripple and subtraction corner cases.
    task automatic test_directed();
        logic [N-1:0] ta[5]  = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'h80000000, 32'd9};
        logic [N-1:0] tb_[5] = '{32'h1, 32'h1, 32'd7, 32'h1, 32'd4};
        logic         tc[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic         ts[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [N-1:0] es[5]  = '{32'h0, 32'h80000000, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'd5};
        logic         ec[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic         eo[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic ok;
        int   lat;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_op(ta[i], tb_[i], tc[i], ts[i], ok);
            wait_out(lat);
            n_vec++;
            if (!ok || lat !== S) begin
                n_fail++;
                $display("FAIL directed%0d_latency: got accepted=%b latency %0d, required 1/%0d", i, ok, lat, S);
            end
            n_vec++;
            if ({out_valid, cout, ovf, sum} !== {1'b1, ec[i], eo[i], es[i]}) begin
                n_fail++;
                $display("FAIL directed%0d_value: got valid/cout/ovf/sum %b/%b/%b/%h, required 1/%b/%b/%h",
                         i, out_valid, cout, ovf, sum, ec[i], eo[i], es[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        int   acc;
        int   streak;
        logic took;
        logic took5;
        out_ready = 1'b0;
        a = 32'd100; b = 32'd1; cin = 1'b0; sb = 1'b0; in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                acc++;
                a = a + 1;
            end
        end
        n_vec++;
        if (acc !== S) begin
            n_fail++;
            $display("FAIL bp_accept_count: got %0d, required %0d", acc, S);
        end
        n_vec++;
        if ({in_ready, out_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_full_state: got in_ready/out_valid %b/%b, required 0/1", in_ready, out_valid);
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_on_drain: got %b, required 1", in_ready);
        end
        streak = 0;
        took5 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) streak++;
            if (i == 0) took5 = in_valid && in_ready;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        n_vec++;
        if (streak !== 4 || took5 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d consecutive results, 5th accepted=%b, required 4/1", streak, took5);
        end
        wait_drain();
    endtask

    task automatic test_stream(input int nops);
        int   cnt;
        int   guard;
        logic took;
        cnt = 0;
        guard = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (cnt < nops && guard < 20000) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (took) cnt++;
            if (!in_valid || took) begin
                in_valid = (cnt < nops) ? 1'($urandom_range(0, 1)) : 1'b0;
                a   = $urandom;
                b   = $urandom;
                cin = 1'($urandom_range(0, 1));
                sb  = 1'($urandom_range(0, 1));
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (cnt !== nops) begin
            n_fail++;
            $display("FAIL stream_count: got %0d accepted, required %0d", cnt, nops);
        end
        wait_drain();
    endtask

    task automatic test_reset_midflight();
        logic ok;
        int   lat;
        int   stray;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_op(32'h11 + 32'(i), 32'h22, 1'b0, 1'b0, ok);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        in_valid = 1'b1;
        #1;
        n_vec++;
        if ({out_valid, sum, in_ready} !== {1'b0, {N{1'b0}}, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_async: got valid/sum/in_ready %b/%h/%b, required 0/0/0", out_valid, sum, in_ready);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_hold_ready: got %b, required 0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
        end
        n_vec++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_stray: got %0d stale results, required 0", stray);
        end
        drive_op(32'h10, 32'h20, 1'b0, 1'b0, ok);
        wait_out(lat);
        n_vec++;
        if (!ok || lat !== S || {out_valid, sum} !== {1'b1, 32'h30}) begin
            n_fail++;
            $display("FAIL rst_mid_next: got accepted=%b latency %0d valid/sum %b/%h, required 1/%0d 1/30",
                     ok, lat, out_valid, sum, S);
        end
        @(posedge clk);
        #1;
        wait_drain();
    endtask

    // ---------------- parameter corners ----------------
    for (genvar g = 0; g < 3; g++) begin : corner
        localparam int CN = (g == 2) ? 8 : 32;
        localparam int CS = (g == 0) ? 1 : ((g == 1) ? 32 : 2);

        logic          c_iv = 1'b0;
        logic          c_ir;
        logic [CN-1:0] c_a = '0;
        logic [CN-1:0] c_b = '0;
        logic          c_cin = 1'b0;
        logic          c_sub = 1'b0;
        logic          c_ov;
        logic          c_or = 1'b1;
        logic [CN-1:0] c_sum;
        logic          c_cout;
        logic          c_ovf;
        logic          done_g = 1'b0;
        logic [CN+1:0] q[$];
        logic [CN+1:0] e;
        logic [CN-1:0] be;
        logic [CN:0]   full;

        pipelined_carry_adder #(.N(CN), .STAGES(CS)) dut_c (
            .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir),
            .A(c_a), .B(c_b), .Cin(c_cin), .sub(c_sub),
            .out_valid(c_ov), .out_ready(c_or),
            .Sum(c_sum), .Cout(c_cout), .Ovf(c_ovf)
        );

        always @(negedge clk) begin
            if (rst) begin
                q.delete();
            end else begin
                if (c_ov && c_or) begin
                    n_vec++;
                    if (q.size() == 0 || q.size() > CS) begin
                        n_fail++;
                        $display("FAIL corner%0d_occupancy: got %0d in flight, required 1..%0d", g, q.size(), CS);
                        if (q.size() != 0) e = q.pop_front();
                    end else begin
                        e = q.pop_front();
                        if ({c_cout, c_ovf, c_sum} !== e) begin
                            n_fail++;
                            $display("FAIL corner%0d_result: got %h, required %h", g, {c_cout, c_ovf, c_sum}, e);
                        end
                    end
                end
                if (c_iv && c_ir) begin
                    be   = c_sub ? ~c_b : c_b;
                    full = {1'b0, c_a} + {1'b0, be} + {{CN{1'b0}}, (c_sub ? 1'b1 : c_cin)};
                    q.push_back({full[CN], (c_a[CN-1] == be[CN-1]) && (full[CN-1] != c_a[CN-1]),
                                 full[CN-1:0]});
                end
            end
        end

        initial begin
            int            t;
            int            lat;
            int            cnt;
            logic          took;
            logic [CN-1:0] es;
            wait (corner_go == 1'b1);
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                c_a   = (k == 0) ? {CN{1'b1}} : {1'b0, {(CN-1){1'b1}}};
                c_b   = {{(CN-1){1'b0}}, 1'b1};
                es    = (k == 0) ? {CN{1'b0}} : {1'b1, {(CN-1){1'b0}}};
                c_cin = 1'b0; c_sub = 1'b0; c_iv = 1'b1; c_or = 1'b1;
                took = 1'b0;
                t = 0;
                while (!took && t < 200) begin
                    @(negedge clk);
                    took = c_ir;
                    @(posedge clk);
                    #1;
                    t++;
                end
                c_iv = 1'b0;
                lat = 1;
                while (!c_ov && lat < 100) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                n_vec++;
                if (lat !== CS || c_sum !== es) begin
                    n_fail++;
                    $display("FAIL corner%0d_ripple%0d: got latency %0d sum %h, required %0d/%h", g, k, lat, c_sum, CS, es);
                end
                @(posedge clk);
                #1;
            end
            cnt = 0;
            t = 0;
            while (cnt < 300 && t < 20000) begin
                @(negedge clk);
                took = c_iv && c_ir;
                @(posedge clk);
                #1;
                t++;
                if (took) cnt++;
                if (!c_iv || took) begin
                    c_iv  = (cnt < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
                    c_a   = CN'($urandom);
                    c_b   = CN'($urandom);
                    c_cin = 1'($urandom_range(0, 1));
                    c_sub = 1'($urandom_range(0, 1));
                end
                c_or = 1'($urandom_range(0, 1));
            end
            c_iv = 1'b0;
            c_or = 1'b1;
            t = 0;
            while (q.size() != 0 && t < 500) begin
                @(posedge clk);
                #1;
                t++;
            end
            n_vec++;
            if (cnt !== 300 || q.size() != 0) begin
                n_fail++;
                $display("FAIL corner%0d_stream: got %0d accepted %0d outstanding, required 300/0", g, cnt, q.size());
            end
            done_g = 1'b1;
        end
    end

    // ---------------- main sequence and report ----------------
    initial begin
        int t;
        test_reset();
        test_directed();
        test_backpressure();
        test_stream(1000);
        test_reset_midflight();
        corner_go = 1'b1;
        t = 0;
        while (!(corner[0].done_g && corner[1].done_g && corner[2].done_g) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        n_vec++;
        if (!(corner[0].done_g && corner[1].done_g && corner[2].done_g)) begin
            n_fail++;
            $display("FAIL corner_timeout: got done %b%b%b, required 111",
                     corner[2].done_g, corner[1].done_g, corner[0].done_g);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
